// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown control stage: FSM encodings,
// the default preset, the BCD zero constant and the BCD validity helper.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    // {dozens[1:0], units[3:0]} loaded into the counter on start (BCD 30)
    localparam logic [5:0] PRESET_DEFAULT = 6'b11_0000;
    localparam logic [5:0] BCD_ZERO       = 6'b00_0000;

    // A value is invalid when the units digit is not BCD, or when it exceeds 30.
    function automatic logic bcd_invalid(input logic [1:0] dz, input logic [3:0] un);
        return (un > 4'd9) || ((dz == 2'd3) && (un != 4'd0));
    endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Link between the control stage and the BCD countdown counter.
// The controller (master) drives the strobes and preset and reads the digits.
interface countdown_ctrl_if;
    logic [1:0] dozens;
    logic [3:0] units;
    logic       count_en;
    logic       load;
    logic [5:0] preset_value;

    modport master (
        input  dozens,
        input  units,
        output count_en,
        output load,
        output preset_value
    );

    modport slave (
        output dozens,
        output units,
        input  count_en,
        input  load,
        input  preset_value
    );
endinterface

// File: rtl/btn_debounce.sv
// Active-low push-button conditioner: two-flop synchronizer, stability
// counter, and a one-cycle press pulse on the debounced falling edge.
// A held button produces a single press; release must also be stable.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;
    logic          stable_s;

    assign stable_s = (cnt_r == CNT_LAST);
    assign press    = press_r;

    // Bring the asynchronous button into the clock domain (idle level is high).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it differs from the current one for DB_CYCLES cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r   <= '0;
            level_r <= 1'b1;
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (stable_s) begin
                cnt_r   <= '0;
                level_r <= sync2_r;
                press_r <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CW'(32'd1);
            end
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Control stage for the 30-to-0 BCD countdown counter: button handling,
// run/pause/done FSM, one-second prescaler, load strobe, expiry and
// invalid-BCD detection. Every output except the constant preset is a flop.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int         TICK_DIV  = 50_000_000,
    parameter int         DB_CYCLES = 1_000_000,
    parameter logic [5:0] PRESET    = PRESET_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             pause_btn,
    countdown_ctrl_if.master cnt,
    output logic [1:0]       state,
    output logic             running,
    output logic             done,
    output logic             bcd_err
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic          load_r;
    logic          load_nxt_s;
    logic          count_en_r;
    logic          running_r;
    logic          done_r;
    logic          bcd_err_r;
    logic [PW-1:0] presc_r;
    logic [1:0]    mask_r;

    logic          start_press_s;
    logic          pause_press_s;
    logic          zero_s;
    logic          invalid_s;
    logic          masked_s;
    logic          err_s;
    logic          tick_s;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (start_btn),
        .press   (start_press_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause_db (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (pause_btn),
        .press   (pause_press_s)
    );

    // The counter only shows the loaded value two cycles after a load, so the
    // value checks are masked meanwhile to ignore a stale 00 or stale bad digit.
    assign zero_s    = ({cnt.dozens, cnt.units} == BCD_ZERO);
    assign invalid_s = bcd_invalid(cnt.dozens, cnt.units);
    assign masked_s  = (mask_r != 2'd0);
    assign err_s     = bcd_err_r | (invalid_s & ~masked_s);
    assign tick_s    = (presc_r == PRESC_LAST);

    // Next-state and load decision; start always wins over pause.
    always_comb begin
        state_nxt_s = state_r;
        load_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_press_s) begin
                    state_nxt_s = ST_RUNNING;
                    load_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                if (start_press_s) begin
                    state_nxt_s = ST_RUNNING;
                    load_nxt_s  = 1'b1;
                end else if (err_s) begin
                    state_nxt_s = ST_RUNNING;
                end else if (pause_press_s) begin
                    state_nxt_s = ST_PAUSED;
                end else if (zero_s && !masked_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUNNING;
                end
            end
            ST_PAUSED: begin
                if (start_press_s) begin
                    state_nxt_s = ST_RUNNING;
                    load_nxt_s  = 1'b1;
                end else if (err_s) begin
                    state_nxt_s = ST_PAUSED;
                end else if (pause_press_s) begin
                    state_nxt_s = ST_RUNNING;
                end else begin
                    state_nxt_s = ST_PAUSED;
                end
            end
            ST_DONE: begin
                if (start_press_s) begin
                    state_nxt_s = ST_RUNNING;
                    load_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                load_nxt_s  = 1'b0;
            end
        endcase
    end

    // State register plus registered status and load strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            load_r    <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            load_r    <= load_nxt_s;
            running_r <= (state_nxt_s == ST_RUNNING);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    // Prescaler advances only while running, keeps its phase across a pause,
    // and restarts from zero on every load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_r    <= '0;
            count_en_r <= 1'b0;
        end else begin
            count_en_r <= 1'b0;
            if (load_nxt_s) begin
                presc_r <= '0;
            end else if (state_r == ST_RUNNING) begin
                if (tick_s) begin
                    presc_r    <= '0;
                    count_en_r <= ~zero_s & ~err_s;
                end else begin
                    presc_r <= presc_r + PW'(32'd1);
                end
            end else begin
                presc_r <= presc_r;
            end
        end
    end

    // Load mask window and sticky invalid-BCD flag (cleared only by a load).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask_r    <= 2'd0;
            bcd_err_r <= 1'b0;
        end else begin
            if (load_nxt_s) begin
                mask_r    <= 2'd2;
                bcd_err_r <= 1'b0;
            end else begin
                if (masked_s) begin
                    mask_r <= mask_r - 2'd1;
                end else begin
                    mask_r <= 2'd0;
                end
                if (invalid_s && !masked_s) begin
                    bcd_err_r <= 1'b1;
                end else begin
                    bcd_err_r <= bcd_err_r;
                end
            end
        end
    end

    assign cnt.count_en     = count_en_r;
    assign cnt.load         = load_r;
    assign cnt.preset_value = PRESET;
    assign state            = state_r;
    assign running          = running_r;
    assign done             = done_r;
    assign bcd_err          = bcd_err_r;

endmodule
